bf4_dif: RTL and testbench

Pipelined radix-4 decimation-in-frequency butterfly for the FFT-1024 datapath. It sits directly downstream of the serial-to-parallel converters: one converter for real parts and one for imaginary parts each present four samples per group, and this block takes them as one complex 4-tuple. It computes the four radix-4 outputs, applies per-stage scaling with rounding and saturation, and presents the results to the twiddle-multiply stage three enabled cycles later.

---
 rtl/bf4_dif_pkg.sv | 50 +++++
 rtl/bf4_sat_round.sv | 20 ++
 rtl/bf4_dif.sv | 174 +++++++++++++++++
 tb/tb_bf4_dif.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf4_dif_pkg.sv
// Shared FFT datapath definitions: default word length, guard bits and the
// round/saturate arithmetic reused by every scaling stage of the FFT-1024.
package bf4_dif_pkg;

  localparam int DEFAULT_WORDLENGTH = 16;
  localparam int GUARD_BITS         = 2;
  localparam int ACC_W              = 64;

  // Round-half-up arithmetic right shift; shift code 3 behaves as 2.
  function automatic logic signed [ACC_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] v,
    input logic [1:0]              shift
  );
    logic [1:0] s;
    s = (shift == 2'd3) ? 2'd2 : shift;
    if (s == 2'd0) return v;
    return (v + (64'sd1 <<< (s - 2'd1))) >>> s;
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_round(
    input logic signed [ACC_W-1:0] v,
    input int                      w,
    input logic [1:0]              shift
  );
    logic signed [ACC_W-1:0] r;
    r = round_shift(v, shift);
    if (r > sat_max(w)) return sat_max(w);
    if (r < sat_min(w)) return sat_min(w);
    return r;
  endfunction

  function automatic logic sat_detect(
    input logic signed [ACC_W-1:0] v,
    input int                      w,
    input logic [1:0]              shift
  );
    logic signed [ACC_W-1:0] r;
    r = round_shift(v, shift);
    return (r > sat_max(w)) || (r < sat_min(w));
  endfunction

endpackage

// File: rtl/bf4_sat_round.sv
// Combinational W+3 -> W rounding/saturation slice; the owning stage registers
// the result and collects the saturation flag.
module bf4_sat_round
  import bf4_dif_pkg::*;
#(
  parameter int W = DEFAULT_WORDLENGTH
) (
  input  logic signed [W+GUARD_BITS:0] y_i,
  input  logic [1:0]                   shift_i,
  output logic signed [W-1:0]          q_o,
  output logic                         sat_o
);

  logic signed [ACC_W-1:0] y_ext;

  assign y_ext = ACC_W'(y_i);
  assign q_o   = W'(sat_round(y_ext, W, shift_i));
  assign sat_o = sat_detect(y_ext, W, shift_i);

endmodule

// File: rtl/bf4_dif.sv
// Three-stage pipelined radix-4 DIF butterfly: pre-sums, cross terms with the
// -j rotation, then per-word round/saturate into the output registers.
module bf4_dif
  import bf4_dif_pkg::*;
#(
  parameter int WORDLENGTH = DEFAULT_WORDLENGTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         in_valid,
  input  logic [1:0]                   shift,
  input  logic                         clr_ovf,
  input  logic signed [WORDLENGTH-1:0] in0_re,
  input  logic signed [WORDLENGTH-1:0] in1_re,
  input  logic signed [WORDLENGTH-1:0] in2_re,
  input  logic signed [WORDLENGTH-1:0] in3_re,
  input  logic signed [WORDLENGTH-1:0] in0_im,
  input  logic signed [WORDLENGTH-1:0] in1_im,
  input  logic signed [WORDLENGTH-1:0] in2_im,
  input  logic signed [WORDLENGTH-1:0] in3_im,
  output logic signed [WORDLENGTH-1:0] out0_re,
  output logic signed [WORDLENGTH-1:0] out1_re,
  output logic signed [WORDLENGTH-1:0] out2_re,
  output logic signed [WORDLENGTH-1:0] out3_re,
  output logic signed [WORDLENGTH-1:0] out0_im,
  output logic signed [WORDLENGTH-1:0] out1_im,
  output logic signed [WORDLENGTH-1:0] out2_im,
  output logic signed [WORDLENGTH-1:0] out3_im,
  output logic                         out_valid,
  output logic                         ovf
);

  localparam int W  = WORDLENGTH;
  localparam int S2 = W + GUARD_BITS;

  logic signed [W:0]    x_re [4];
  logic signed [W:0]    x_im [4];
  logic signed [W:0]    s1_re_d [4], s1_im_d [4];
  logic signed [W:0]    s1_re_q [4], s1_im_q [4];
  logic                 v1_q;
  logic signed [S2-1:0] ar, br, cr, dr, ai, bi, ci, di;
  logic signed [S2-1:0] y_re_d [4], y_im_d [4];
  logic signed [S2-1:0] y_re_q [4], y_im_q [4];
  logic                 v2_q;
  logic signed [W-1:0]  o_re_d [4], o_im_d [4];
  logic signed [W-1:0]  o_re_q [4], o_im_q [4];
  logic [3:0]           sat_re, sat_im;
  logic                 out_valid_q, ovf_q;

  assign x_re[0] = (W+1)'(in0_re);
  assign x_re[1] = (W+1)'(in1_re);
  assign x_re[2] = (W+1)'(in2_re);
  assign x_re[3] = (W+1)'(in3_re);
  assign x_im[0] = (W+1)'(in0_im);
  assign x_im[1] = (W+1)'(in1_im);
  assign x_im[2] = (W+1)'(in2_im);
  assign x_im[3] = (W+1)'(in3_im);

  // Stage 1 order: a = x0+x2, b = x0-x2, c = x1+x3, d = x1-x3.
  // NOTE: every always_comb output is fully assigned on each pass, so no latch is inferred.
  always_comb begin
    s1_re_d[0] = x_re[0] + x_re[2];
    s1_re_d[1] = x_re[0] - x_re[2];
    s1_re_d[2] = x_re[1] + x_re[3];
    s1_re_d[3] = x_re[1] - x_re[3];
    s1_im_d[0] = x_im[0] + x_im[2];
    s1_im_d[1] = x_im[0] - x_im[2];
    s1_im_d[2] = x_im[1] + x_im[3];
    s1_im_d[3] = x_im[1] - x_im[3];
  end

  // NOTE: non-blocking assignments keep every stage reading last cycle's values.
  // NOTE: data registers are few and the reset state is architectural, so they reset too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        s1_re_q[k] <= '0;
        s1_im_q[k] <= '0;
      end
    end else if (enable) begin
      v1_q <= in_valid;
      if (in_valid) begin
        s1_re_q <= s1_re_d;
        s1_im_q <= s1_im_d;
      end
    end
  end

  assign ar = S2'(s1_re_q[0]);
  assign br = S2'(s1_re_q[1]);
  assign cr = S2'(s1_re_q[2]);
  assign dr = S2'(s1_re_q[3]);
  assign ai = S2'(s1_im_q[0]);
  assign bi = S2'(s1_im_q[1]);
  assign ci = S2'(s1_im_q[2]);
  assign di = S2'(s1_im_q[3]);

  // y1 takes -j*d, y3 takes +j*d: a real/imag swap with one sign flip.
  always_comb begin
    y_re_d[0] = ar + cr;
    y_im_d[0] = ai + ci;
    y_re_d[1] = br + di;
    y_im_d[1] = bi - dr;
    y_re_d[2] = ar - cr;
    y_im_d[2] = ai - ci;
    y_re_d[3] = br - di;
    y_im_d[3] = bi + dr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        y_re_q[k] <= '0;
        y_im_q[k] <= '0;
      end
    end else if (enable) begin
      v2_q <= v1_q;
      if (v1_q) begin
        y_re_q <= y_re_d;
        y_im_q <= y_im_d;
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_sat
    bf4_sat_round #(.W(W)) u_re (
      .y_i     ((S2+1)'(y_re_q[k])),
      .shift_i (shift),
      .q_o     (o_re_d[k]),
      .sat_o   (sat_re[k])
    );
    bf4_sat_round #(.W(W)) u_im (
      .y_i     ((S2+1)'(y_im_q[k])),
      .shift_i (shift),
      .q_o     (o_im_d[k]),
      .sat_o   (sat_im[k])
    );
  end

  // A saturation in the loading cycle overrides a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        o_re_q[k] <= '0;
        o_im_q[k] <= '0;
      end
    end else if (enable) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        o_re_q <= o_re_d;
        o_im_q <= o_im_d;
      end
      if (v2_q && (|{sat_re, sat_im})) ovf_q <= 1'b1;
      else if (clr_ovf)                ovf_q <= 1'b0;
    end
  end

  assign out0_re   = o_re_q[0];
  assign out1_re   = o_re_q[1];
  assign out2_re   = o_re_q[2];
  assign out3_re   = o_re_q[3];
  assign out0_im   = o_im_q[0];
  assign out1_im   = o_im_q[1];
  assign out2_im   = o_im_q[2];
  assign out3_im   = o_im_q[3];
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bf4_dif.sv
// Directed bench for bf4_dif: table of single-group vectors with hand-computed
// results, then multi-cycle sequences for ovf, shift timing, streaming and reset.
module tb_bf4_dif;

  typedef struct {
    string name;
    int    xr [4];
    int    xi [4];
    int    sh;
    int    er [4];
    int    ei [4];
    int    eovf;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable, in_valid, clr_ovf;
  logic [1:0]         shift;
  logic signed [15:0] in_re [4];
  logic signed [15:0] in_im [4];
  logic signed [15:0] out_re [4];
  logic signed [15:0] out_im [4];
  logic               out_valid, ovf;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   got      = 0;
  int   exp_q [$];
  vec_t vecs [11];

  always #5 clk = ~clk;

  bf4_dif #(.WORDLENGTH(16)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .shift     (shift),
    .clr_ovf   (clr_ovf),
    .in0_re    (in_re[0]),
    .in1_re    (in_re[1]),
    .in2_re    (in_re[2]),
    .in3_re    (in_re[3]),
    .in0_im    (in_im[0]),
    .in1_im    (in_im[1]),
    .in2_im    (in_im[2]),
    .in3_im    (in_im[3]),
    .out0_re   (out_re[0]),
    .out1_re   (out_re[1]),
    .out2_re   (out_re[2]),
    .out3_re   (out_re[3]),
    .out0_im   (out_im[0]),
    .out1_im   (out_im[1]),
    .out2_im   (out_im[2]),
    .out3_im   (out_im[3]),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      in_re[k] = 16'(v.xr[k]);
      in_im[k] = 16'(v.xi[k]);
    end
    shift = 2'(v.sh);
  endtask

  task automatic send(input vec_t v, output int lat);
    set_inputs(v);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin
      tick;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    send(v, lat);
    check($sformatf("%s_latency", v.name), lat, 2);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_y%0d_re", v.name, k), out_re[k], v.er[k]);
      check($sformatf("%s_y%0d_im", v.name, k), out_im[k], v.ei[k]);
    end
    check($sformatf("%s_ovf", v.name), ovf, v.eovf);
    tick;
    check($sformatf("%s_strobe_low", v.name), out_valid, 0);
    check($sformatf("%s_hold", v.name), out_re[0], v.er[0]);
  endtask

  // Streaming capture: only an enabled edge with out_valid high is a new group.
  task automatic tick_cap;
    bit en;
    int g;
    en = enable;
    tick;
    if (en && out_valid) begin
      got++;
      if (exp_q.size() == 0) check("stream_extra_group", 1, 0);
      else begin
        g = exp_q.pop_front();
        check($sformatf("stream_g%0d_y0_re", g), out_re[0], 100 + g);
        check($sformatf("stream_g%0d_y2_im", g), out_im[2], -g - 1);
      end
    end
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{"dc",     '{100, 100, 100, 100}, '{0, 0, 0, 0}, 0, '{400, 0, 0, 0}, '{0, 0, 0, 0}, 0};
    vecs[1]  = '{"j1",     '{0, 0, 0, 0}, '{0, 100, 0, 0}, 0, '{0, 100, 0, -100}, '{100, 0, -100, 0}, 0};
    vecs[2]  = '{"satpos", '{32767, 32767, 32767, 32767}, '{0, 0, 0, 0}, 0, '{32767, 0, 0, 0}, '{0, 0, 0, 0}, 1};
    vecs[3]  = '{"sh2",    '{6, 0, 0, 0}, '{0, 0, 0, 0}, 2, '{2, 2, 2, 2}, '{0, 0, 0, 0}, 0};
    vecs[4]  = '{"sh1",    '{6, 0, 0, 0}, '{0, 0, 0, 0}, 1, '{3, 3, 3, 3}, '{0, 0, 0, 0}, 0};
    vecs[5]  = '{"negsh2", '{-6, 0, 0, 0}, '{0, 0, 0, 0}, 2, '{-1, -1, -1, -1}, '{0, 0, 0, 0}, 0};
    vecs[6]  = '{"sh3",    '{10, 0, 0, 0}, '{0, 0, 0, 0}, 3, '{3, 3, 3, 3}, '{0, 0, 0, 0}, 0};
    vecs[7]  = '{"mix",    '{1, 3, 5, 7}, '{2, 4, 6, 8}, 0, '{16, -8, -4, 0}, '{20, 0, -4, -8}, 0};
    vecs[8]  = '{"satneg", '{-32768, -32768, -32768, -32768}, '{0, 0, 0, 0}, 0, '{-32768, 0, 0, 0}, '{0, 0, 0, 0}, 1};
    vecs[9]  = '{"maxsh2", '{32767, 32767, 32767, 32767}, '{0, 0, 0, 0}, 2, '{32767, 0, 0, 0}, '{0, 0, 0, 0}, 0};
    vecs[10] = '{"maxsh1", '{32767, 32767, 32767, 32767}, '{0, 0, 0, 0}, 1, '{32767, 0, 0, 0}, '{0, 0, 0, 0}, 1};

    rst_n    = 1'b0;
    enable   = 1'b1;
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    shift    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      in_re[k] = '0;
      in_im[k] = '0;
    end
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_ovf", ovf, 0);
    check("reset_y0_re", out_re[0], 0);
    check("reset_y3_im", out_im[3], 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // ovf is sticky across non-saturating groups and clears only when enabled
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    send(vecs[2], lat);
    send(vecs[0], lat);
    check("ovf_sticky", ovf, 1);
    enable  = 1'b0;
    clr_ovf = 1'b1;
    tick;
    check("ovf_clr_frozen", ovf, 1);
    enable = 1'b1;
    tick;
    clr_ovf = 1'b0;
    check("ovf_cleared", ovf, 0);

    // Saturation and clr_ovf on the same enabled edge: set wins
    clr_ovf = 1'b1;
    send(vecs[2], lat);
    check("ovf_set_wins", ovf, 1);
    tick;
    clr_ovf = 1'b0;
    check("ovf_clear_after", ovf, 0);

    // shift is taken when the result is registered, not when input is sampled
    set_inputs(vecs[3]);
    shift    = 2'd0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    shift    = 2'd2;
    tick;
    tick;
    check("late_shift_valid", out_valid, 1);
    check("late_shift_y0_re", out_re[0], 2);

    // out_valid stays high across a freeze and drops on the next enabled edge
    send(vecs[0], lat);
    enable = 1'b0;
    repeat (2) tick;
    check("freeze_out_valid", out_valid, 1);
    check("freeze_y0_re", out_re[0], 400);
    enable = 1'b1;
    tick;
    check("unfreeze_strobe_low", out_valid, 0);

    // Back-to-back groups with a two-cycle enable gap mid-stream
    shift = 2'd0;
    got   = 0;
    for (int g = 0; g < 8; g++) begin
      if (g == 4) begin
        enable   = 1'b0;
        in_valid = 1'b1;
        in_re[0] = 16'sd999;
        in_im[0] = 16'sd999;
        tick_cap;
        check("stream_freeze_valid_held", out_valid, 1);
        tick_cap;
        enable = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        in_re[k] = '0;
        in_im[k] = '0;
      end
      in_re[0] = 16'(100 + g);
      in_im[0] = 16'(-g - 1);
      in_valid = 1'b1;
      exp_q.push_back(g);
      tick_cap;
    end
    in_valid = 1'b0;
    repeat (6) tick_cap;
    check("stream_group_count", got, 8);
    check("stream_pending", exp_q.size(), 0);

    // Reset mid-flight discards the group and zeroes outputs asynchronously
    set_inputs(vecs[0]);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_async_y0_re", out_re[0], 0);
    tick;
    rst_n = 1'b1;
    seen  = 0;
    repeat (5) begin
      tick;
      if (out_valid) seen++;
    end
    check("rst_no_out_valid", seen, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_y%0d_re", k), out_re[k], 0);
      check($sformatf("rst_y%0d_im", k), out_im[k], 0);
    end
    check("rst_ovf", ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
